// File: rtl/debouncer_bank.sv
// debouncer_bank: multi-channel push-button / switch debouncer.
//
// Each channel passes its raw pad input through a 2-flop synchroniser. It
// then uses a two-state FSM (STABLE / CHANGE) with an integration counter
// to commit a new level once DEBOUNCE_CYCLES consecutive synchronised
// samples disagree with the current debounced level. A single sample that
// agrees with the current level restarts integration from zero.
//
// Optional long-press detector, compiled in when the macro DEBOUNCE_HOLD_EN
// is defined. Without it, hold_out and hold_pulse are tied to 0 and the
// port list is unchanged.
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous, active-high reset
//   button_in      [CHANNELS] raw, asynchronous, bouncing inputs
//   debounced_out  [CHANNELS] registered debounced level
//   rise_pulse     [CHANNELS] one-cycle strobe on a committed 0->1
//   fall_pulse     [CHANNELS] one-cycle strobe on a committed 1->0
//   any_change     OR of all rise/fall strobes, same cycle as the strobes
//   hold_out       [CHANNELS] level: debounced high for >= HOLD_CYCLES
//   hold_pulse     [CHANNELS] one-cycle strobe when hold_out rises
module debouncer_bank #(
  parameter int unsigned CHANNELS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 700_000,
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned HOLD_CYCLES     = 10_000_000,
  parameter int unsigned HOLD_W          = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] button_in,
  output logic [CHANNELS-1:0] debounced_out,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
  output logic                any_change,
  output logic [CHANNELS-1:0] hold_out,
  output logic [CHANNELS-1:0] hold_pulse
);

  // Elaboration-time sanity check of the parameter set.
  generate
    if (CHANNELS < 32'd1 || DEBOUNCE_CYCLES < 32'd1 || HOLD_CYCLES < 32'd1 ||
        (64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES) ||
        (64'd1 << HOLD_W) <= 64'(HOLD_CYCLES)) begin : g_bad_params
      $error("debouncer_bank: illegal parameter combination");
    end
  endgenerate

  localparam logic [0:0]       ST_STABLE  = 1'b0;
  localparam logic [0:0]       ST_CHANGE  = 1'b1;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(DEBOUNCE_CYCLES);

  logic [CHANNELS-1:0] sync1_q, sync2_q;
  logic [CHANNELS-1:0] state_q, state_d;
  logic [CNT_W-1:0]    cnt_q [CHANNELS];
  logic [CNT_W-1:0]    cnt_d [CHANNELS];
  logic [CHANNELS-1:0] deb_q, deb_d;
  logic [CHANNELS-1:0] rise_q, rise_d;
  logic [CHANNELS-1:0] fall_q, fall_d;
  logic                any_q;

  // Two-flop synchroniser for the asynchronous pad inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= button_in;
      sync2_q <= sync1_q;
    end
  end

  // Per-channel integration FSM. The counter holds the number of
  // consecutive mismatching samples seen so far. The commit fires on the
  // edge that consumes the DEBOUNCE_CYCLES-th one, which is why a
  // DEBOUNCE_CYCLES of 1 commits straight out of STABLE.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      state_d[c] = ST_STABLE;
      cnt_d[c]   = '0;
      deb_d[c]   = deb_q[c];
      rise_d[c]  = 1'b0;
      fall_d[c]  = 1'b0;
      case (state_q[c])
        ST_STABLE: begin
          if (sync2_q[c] != deb_q[c]) begin
            if (CNT_ONE == CNT_TARGET) begin
              deb_d[c]  = sync2_q[c];
              rise_d[c] = sync2_q[c];
              fall_d[c] = ~sync2_q[c];
            end else begin
              state_d[c] = ST_CHANGE;
              cnt_d[c]   = CNT_ONE;
            end
          end else begin
            state_d[c] = ST_STABLE;
          end
        end
        ST_CHANGE: begin
          if (sync2_q[c] == deb_q[c]) begin
            state_d[c] = ST_STABLE;
          end else if ((cnt_q[c] + CNT_ONE) == CNT_TARGET) begin
            deb_d[c]  = sync2_q[c];
            rise_d[c] = sync2_q[c];
            fall_d[c] = ~sync2_q[c];
          end else begin
            state_d[c] = ST_CHANGE;
            cnt_d[c]   = cnt_q[c] + CNT_ONE;
          end
        end
        default: begin
          state_d[c] = ST_STABLE;
        end
      endcase
    end
  end

  // FSM, counter, level and strobe registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= {CHANNELS{ST_STABLE}};
      deb_q   <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      any_q   <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) cnt_q[c] <= '0;
    end else begin
      state_q <= state_d;
      deb_q   <= deb_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      any_q   <= |(rise_d | fall_d);
      for (int c = 0; c < CHANNELS; c++) cnt_q[c] <= cnt_d[c];
    end
  end

  assign debounced_out = deb_q;
  assign rise_pulse    = rise_q;
  assign fall_pulse    = fall_q;
  assign any_change    = any_q;

`ifdef DEBOUNCE_HOLD_EN
  localparam logic [HOLD_W-1:0] HOLD_ONE    = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_TARGET = HOLD_W'(HOLD_CYCLES);

  logic [HOLD_W-1:0]   hold_cnt_q [CHANNELS];
  logic [HOLD_W-1:0]   hold_cnt_d [CHANNELS];
  logic [CHANNELS-1:0] hold_out_q, hold_out_d;
  logic [CHANNELS-1:0] hold_pulse_q, hold_pulse_d;

  // Saturating hold counter. It clears using the next debounced level so
  // that hold_out drops on the same edge as debounced_out. It counts only
  // while the registered level is already high, so that hold_out rises
  // HOLD_CYCLES edges after the rise strobe.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      hold_cnt_d[c]   = hold_cnt_q[c];
      hold_out_d[c]   = hold_out_q[c];
      hold_pulse_d[c] = 1'b0;
      if (!deb_d[c]) begin
        hold_cnt_d[c] = '0;
        hold_out_d[c] = 1'b0;
      end else if (deb_q[c] && (hold_cnt_q[c] != HOLD_TARGET)) begin
        hold_cnt_d[c] = hold_cnt_q[c] + HOLD_ONE;
        if ((hold_cnt_q[c] + HOLD_ONE) == HOLD_TARGET) begin
          hold_out_d[c]   = 1'b1;
          hold_pulse_d[c] = 1'b1;
        end else begin
          hold_out_d[c] = hold_out_q[c];
        end
      end else begin
        hold_cnt_d[c] = hold_cnt_q[c];
      end
    end
  end

  // Hold counter and long-press output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_out_q   <= '0;
      hold_pulse_q <= '0;
      for (int c = 0; c < CHANNELS; c++) hold_cnt_q[c] <= '0;
    end else begin
      hold_out_q   <= hold_out_d;
      hold_pulse_q <= hold_pulse_d;
      for (int c = 0; c < CHANNELS; c++) hold_cnt_q[c] <= hold_cnt_d[c];
    end
  end

  assign hold_out   = hold_out_q;
  assign hold_pulse = hold_pulse_q;
`else
  assign hold_out   = '0;
  assign hold_pulse = '0;
`endif

endmodule

// File: tb/tb_debouncer_bank.sv
// Self-checking bench for debouncer_bank (CHANNELS=4, DEBOUNCE_CYCLES=8,
// HOLD_CYCLES=20). The reference model works in terms of the observable
// rule: a level commits once D consecutive synchronised samples disagree
// with it. The synchronised sample is the raw input from two edges earlier.
module tb_debouncer_bank;
  localparam int N = 4;
  localparam int D = 8;
  localparam int H = 20;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] button_in = 4'hF;
  logic [N-1:0] debounced_out, rise_pulse, fall_pulse, hold_out, hold_pulse;
  logic         any_change;

  int checks = 0;
  int failures = 0;

  // Reference model state.
  logic [N-1:0] raw_hist [$];
  logic [N-1:0] lvl, e_rise, e_fall, e_hold, e_hpulse;
  int           run [N];
  int           rise_edge [N];
  int           edge_no;

  debouncer_bank #(
    .CHANNELS(N), .DEBOUNCE_CYCLES(D), .CNT_W(4), .HOLD_CYCLES(H), .HOLD_W(5)
  ) dut (
    .clk(clk), .reset(reset), .button_in(button_in),
    .debounced_out(debounced_out), .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse), .any_change(any_change),
    .hold_out(hold_out), .hold_pulse(hold_pulse)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    raw_hist = {};
    raw_hist.push_back('0);
    raw_hist.push_back('0);
    lvl = '0; e_rise = '0; e_fall = '0; e_hold = '0; e_hpulse = '0;
    edge_no = 0;
    for (int c = 0; c < N; c++) begin
      run[c] = 0;
      rise_edge[c] = 0;
    end
  endtask

  // One clock edge: advance the model, then compare every output 1 ns later.
  task automatic tick();
    logic [N-1:0] s;
    @(posedge clk);
    if (reset) begin
      model_clear();
    end else begin
      edge_no++;
      s = raw_hist.pop_front();
      raw_hist.push_back(button_in);
      e_rise = '0; e_fall = '0; e_hpulse = '0;
      for (int c = 0; c < N; c++) begin
        if (s[c] != lvl[c]) begin
          run[c]++;
          if (run[c] == D) begin
            lvl[c] = s[c];
            run[c] = 0;
            if (s[c]) begin
              e_rise[c] = 1'b1;
              rise_edge[c] = edge_no;
            end else begin
              e_fall[c] = 1'b1;
            end
          end
        end else begin
          run[c] = 0;
        end
`ifdef DEBOUNCE_HOLD_EN
        e_hold[c]   = lvl[c] && (edge_no - rise_edge[c] >= H);
        e_hpulse[c] = lvl[c] && (edge_no - rise_edge[c] == H);
`else
        e_hold[c]   = 1'b0;
        e_hpulse[c] = 1'b0;
`endif
      end
    end
    #1;
    check_eq("deb", 32'(debounced_out), 32'(lvl));
    check_eq("rise", 32'(rise_pulse), 32'(e_rise));
    check_eq("fall", 32'(fall_pulse), 32'(e_fall));
    check_eq("any", 32'(any_change), 32'(|(e_rise | e_fall)));
    check_eq("hold", 32'(hold_out), 32'(e_hold));
    check_eq("hpulse", 32'(hold_pulse), 32'(e_hpulse));
  endtask

  // Tick until the masked debounced level equals val; n = edges taken.
  task automatic wait_deb(input logic [N-1:0] mask, input logic [N-1:0] val, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (((debounced_out & mask) != (val & mask)) && n < 40);
  endtask

  initial begin
    int n;
    int cnt;
    logic [N-1:0] acc;
    model_clear();

    // 1: reset with inputs high, then release.
    repeat (3) tick();
    check_eq("t1_rst_deb", 32'(debounced_out), 32'h0);
    reset = 1'b0;
    wait_deb(4'hF, 4'hF, n);
    check_eq("t1_latency", 32'(n), 32'd10);
    check_eq("t1_rise", 32'(rise_pulse), 32'hF);
    check_eq("t1_any", 32'(any_change), 32'h1);
    tick();
    check_eq("t1_rise_once", 32'(rise_pulse), 32'h0);
    button_in = 4'h0;
    wait_deb(4'hF, 4'h0, n);
    check_eq("t1_fall_latency", 32'(n), 32'd10);
    repeat (2) tick();

    // 2: channel 0 step.
    button_in[0] = 1'b1;
    wait_deb(4'h1, 4'h1, n);
    check_eq("t2_latency", 32'(n), 32'd10);
    check_eq("t2_rise", 32'(rise_pulse), 32'h1);
    cnt = 0;
    repeat (5) begin
      tick();
      cnt += int'(rise_pulse[0]);
    end
    check_eq("t2_rise_once", 32'(cnt), 32'd0);

    // 3: channel 1 glitchy pulse, then a real rise.
    button_in[1] = 1'b1;
    acc = '0;
    repeat (7) begin
      tick();
      acc |= rise_pulse | fall_pulse;
    end
    button_in[1] = 1'b0;
    tick();
    acc |= rise_pulse | fall_pulse;
    button_in[1] = 1'b1;
    wait_deb(4'h2, 4'h2, n);
    check_eq("t3_quiet", 32'(acc), 32'h0);
    check_eq("t3_latency", 32'(n), 32'd10);

    // 4: channels 2 and 3 together.
    button_in[3:2] = 2'b11;
    wait_deb(4'hC, 4'hC, n);
    check_eq("t4_latency", 32'(n), 32'd10);
    check_eq("t4_rise", 32'(rise_pulse), 32'hC);
    check_eq("t4_any", 32'(any_change), 32'h1);
    tick();
    check_eq("t4_any_once", 32'(any_change), 32'h0);

    // 5: reset mid-count on channel 0.
    button_in[0] = 1'b0;
    wait_deb(4'h1, 4'h0, n);
    repeat (2) tick();
    button_in[0] = 1'b1;
    repeat (7) tick();
    reset = 1'b1;
    tick();
    check_eq("t5_rst_deb", 32'(debounced_out), 32'h0);
    reset = 1'b0;
    wait_deb(4'h1, 4'h1, n);
    check_eq("t5_latency", 32'(n), 32'd10);

    // 6: long press on channel 0, then release.
`ifdef DEBOUNCE_HOLD_EN
    n = 0;
    do begin
      tick();
      n++;
    end while (!hold_out[0] && n < 40);
    check_eq("t6_hold_latency", 32'(n), 32'd20);
    check_eq("t6_hpulse", 32'(hold_pulse[0]), 32'h1);
    tick();
    check_eq("t6_hpulse_once", 32'(hold_pulse[0]), 32'h0);
    check_eq("t6_hold_level", 32'(hold_out[0]), 32'h1);
`else
    acc = '0;
    repeat (25) begin
      tick();
      acc |= hold_out | hold_pulse;
    end
    check_eq("t6_hold_off", 32'(acc), 32'h0);
`endif
    button_in[0] = 1'b0;
    wait_deb(4'h1, 4'h0, n);
    check_eq("t6_fall_latency", 32'(n), 32'd10);
    check_eq("t6_hold_clear", 32'(hold_out[0]), 32'h0);

    // Randomised phase: sparse toggles so that both commits and bounces
    // occur, plus an occasional reset.
    repeat (1500) begin
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, 9) == 0) button_in[c] = ~button_in[c];
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0;
    repeat (12) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
